qft4_sequencer: RTL and testbench

- Sequences the 4-point QFT on a 2-qubit state vector: out_k = sum_j x_j * w^(j*k), with w = e^(+i*2*pi/4).
- Time-multiplexes one Q2.10 complex multiplier and one accumulator over all 16 matrix terms.
- Replaces four parallel multipliers with a single shared one.
- Sits between the state-vector register file (parallel load) and downstream consumers (one row per valid/ready handshake).

---
 rtl/qft_pkg.sv | 31 +++
 rtl/qft_cmul_q10.sv | 42 ++++
 rtl/qft4_sequencer.sv | 157 +++++++++++++++
 tb/tb_qft4_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/qft_pkg.sv
// ---------------------------------------------------------------------------
// qft_pkg : widths, Q2.10 twiddle ROM and FSM states for the QFT sequencers.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package qft_pkg;

   localparam int DATA_W  = 8;
   localparam int TW_W    = 12;
   localparam int FRAC_W  = 10;
   localparam int OUT_W   = 13;
   localparam int Q10_ONE = 1024;

   // Powers of w = e^(+i*pi/2); index is (j*k) mod 4.
   localparam logic signed [TW_W-1:0] TW_COS [4] = '{
      TW_W'(Q10_ONE), TW_W'(0), TW_W'(-Q10_ONE), TW_W'(0)
   };
   localparam logic signed [TW_W-1:0] TW_SIN [4] = '{
      TW_W'(0), TW_W'(Q10_ONE), TW_W'(0), TW_W'(-Q10_ONE)
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/qft_cmul_q10.sv
// ---------------------------------------------------------------------------
// qft_cmul_q10 : combinational complex multiply by a Q2.10 twiddle, >>> FRAC_W.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qft_cmul_q10
   import qft_pkg::*;
(
   input  logic signed [DATA_W-1:0] a_i,
   input  logic signed [DATA_W-1:0] b_i,
   input  logic signed [TW_W-1:0]   c_i,
   input  logic signed [TW_W-1:0]   s_i,
   output logic signed [OUT_W-1:0]  pr_o,
   output logic signed [OUT_W-1:0]  pi_o
);

   localparam int PROD_W = DATA_W + TW_W;
   localparam int SUM_W  = PROD_W + 1;
   localparam int SHR_W  = SUM_W - FRAC_W;

   logic signed [PROD_W-1:0] w_ac, w_bs, w_as, w_bc;
   logic signed [SUM_W-1:0]  w_sr, w_si;
   logic                     w_unused_frac;

   assign w_ac = PROD_W'(a_i) * PROD_W'(c_i);
   assign w_bs = PROD_W'(b_i) * PROD_W'(s_i);
   assign w_as = PROD_W'(a_i) * PROD_W'(s_i);
   assign w_bc = PROD_W'(b_i) * PROD_W'(c_i);

   assign w_sr = SUM_W'(w_ac) - SUM_W'(w_bs);
   assign w_si = SUM_W'(w_as) + SUM_W'(w_bc);

   // Arithmetic shift by slicing off the fraction, then sign-extend.
   assign pr_o = {{(OUT_W-SHR_W){w_sr[SUM_W-1]}}, w_sr[SUM_W-1:FRAC_W]};
   assign pi_o = {{(OUT_W-SHR_W){w_si[SUM_W-1]}}, w_si[SUM_W-1:FRAC_W]};

   assign w_unused_frac = ^{w_sr[FRAC_W-1:0], w_si[FRAC_W-1:0]};

endmodule

`default_nettype wire

// File: rtl/qft4_sequencer.sv
// ---------------------------------------------------------------------------
// qft4_sequencer : 4-point QFT using one shared complex MAC, one row per handshake.
// Optional: QFT_NORM_EN halves each row (1/sqrt(4) normalisation).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qft4_sequencer
   import qft_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] in_r0,
   input  logic signed [DATA_W-1:0] in_r1,
   input  logic signed [DATA_W-1:0] in_r2,
   input  logic signed [DATA_W-1:0] in_r3,
   input  logic signed [DATA_W-1:0] in_i0,
   input  logic signed [DATA_W-1:0] in_i1,
   input  logic signed [DATA_W-1:0] in_i2,
   input  logic signed [DATA_W-1:0] in_i3,
   output logic                     busy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               out_idx,
   output logic signed [OUT_W-1:0]  out_r,
   output logic signed [OUT_W-1:0]  out_i,
   output logic                     done
);

   state_e                   state_q, state_d;
   logic [1:0]               j_q, j_d, k_q, k_d;
   logic signed [DATA_W-1:0] xr_q [4];
   logic signed [DATA_W-1:0] xi_q [4];
   logic signed [OUT_W-1:0]  acc_r_q, acc_r_d, acc_i_q, acc_i_d;
   logic signed [OUT_W-1:0]  out_r_q, out_r_d, out_i_q, out_i_d;
   logic                     done_q, done_d;
   logic                     w_capture;

   logic [1:0]               w_m;
   logic signed [OUT_W-1:0]  w_pr, w_pi, w_row_r, w_row_i, w_norm_r, w_norm_i;

   assign w_m = j_q * k_q;

   qft_cmul_q10 u_cmul (
      .a_i  (xr_q[j_q]),
      .b_i  (xi_q[j_q]),
      .c_i  (TW_COS[w_m]),
      .s_i  (TW_SIN[w_m]),
      .pr_o (w_pr),
      .pi_o (w_pi)
   );

   assign w_row_r = (j_q == 2'd0) ? w_pr : acc_r_q + w_pr;
   assign w_row_i = (j_q == 2'd0) ? w_pi : acc_i_q + w_pi;

`ifdef QFT_NORM_EN
   assign w_norm_r = w_row_r >>> 1;
   assign w_norm_i = w_row_i >>> 1;
`else
   assign w_norm_r = w_row_r;
   assign w_norm_i = w_row_i;
`endif

   always_comb begin
      state_d   = state_q;
      j_d       = j_q;
      k_d       = k_q;
      acc_r_d   = acc_r_q;
      acc_i_d   = acc_i_q;
      out_r_d   = out_r_q;
      out_i_d   = out_i_q;
      done_d    = 1'b0;
      w_capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               w_capture = 1'b1;
               j_d       = 2'd0;
               k_d       = 2'd0;
               state_d   = MAC;
            end
         end
         MAC: begin
            acc_r_d = w_row_r;
            acc_i_d = w_row_i;
            j_d     = j_q + 2'd1;
            // The last term goes straight into the output register so the
            // row is presented the cycle after its fourth MAC.
            if (j_q == 2'd3) begin
               out_r_d = w_norm_r;
               out_i_d = w_norm_i;
               state_d = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               if (k_q == 2'd3) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  k_d     = k_q + 2'd1;
                  j_d     = 2'd0;
                  state_d = MAC;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         j_q     <= 2'd0;
         k_q     <= 2'd0;
         acc_r_q <= '0;
         acc_i_q <= '0;
         out_r_q <= '0;
         out_i_q <= '0;
         done_q  <= 1'b0;
         for (int n = 0; n < 4; n++) begin
            xr_q[n] <= '0;
            xi_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         k_q     <= k_d;
         acc_r_q <= acc_r_d;
         acc_i_q <= acc_i_d;
         out_r_q <= out_r_d;
         out_i_q <= out_i_d;
         done_q  <= done_d;
         if (w_capture) begin
            xr_q[0] <= in_r0;
            xr_q[1] <= in_r1;
            xr_q[2] <= in_r2;
            xr_q[3] <= in_r3;
            xi_q[0] <= in_i0;
            xi_q[1] <= in_i1;
            xi_q[2] <= in_i2;
            xi_q[3] <= in_i3;
         end
      end
   end

   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == OUT);
   assign out_idx   = k_q;
   assign out_r     = out_r_q;
   assign out_i     = out_i_q;
   assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_qft4_sequencer.sv
// ---------------------------------------------------------------------------
// tb_qft4_sequencer : directed vectors with a queue scoreboard for qft4_sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_qft4_sequencer;
   import qft_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     start;
   logic signed [DATA_W-1:0] in_r0, in_r1, in_r2, in_r3;
   logic signed [DATA_W-1:0] in_i0, in_i1, in_i2, in_i3;
   logic                     busy, out_valid, out_ready, done;
   logic [1:0]               out_idx;
   logic signed [OUT_W-1:0]  out_r, out_i;

   qft4_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_r0     (in_r0),
      .in_r1     (in_r1),
      .in_r2     (in_r2),
      .in_r3     (in_r3),
      .in_i0     (in_i0),
      .in_i1     (in_i1),
      .in_i2     (in_i2),
      .in_i3     (in_i3),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_r     (out_r),
      .out_i     (out_i),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int r;
      int i;
   } row_t;

   row_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual %0d, required %0d", name, act, exp);
   endtask

   function automatic int nrm(input int v);
`ifdef QFT_NORM_EN
      return v >>> 1;
`else
      return v;
`endif
   endfunction

   task automatic push_rows(input int er[4], input int ei[4], input int n);
      row_t e;
      for (int k = 0; k < n; k++) begin
         e.idx = k;
         e.r   = nrm(er[k]);
         e.i   = nrm(ei[k]);
         sb.push_back(e);
      end
   endtask

   task automatic set_x(input int xr[4], input int xi[4]);
      in_r0 = DATA_W'(xr[0]); in_r1 = DATA_W'(xr[1]);
      in_r2 = DATA_W'(xr[2]); in_r3 = DATA_W'(xr[3]);
      in_i0 = DATA_W'(xi[0]); in_i1 = DATA_W'(xi[1]);
      in_i2 = DATA_W'(xi[2]); in_i3 = DATA_W'(xi[3]);
   endtask

   // Monitor: every presented row is checked against the queue head;
   // held rows are re-checked each cycle, accepted rows are popped.
   initial begin
      row_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_row: idx %0d presented with empty scoreboard", out_idx);
            end else begin
               e = sb[0];
               check("row_idx", int'(out_idx), e.idx);
               check("row_r", int'(out_r), e.r);
               check("row_i", int'(out_i), e.i);
               if (out_ready) void'(sb.pop_front());
            end
         end
      end
   end

   task automatic run_xform(input int xr[4], input int xi[4], input int bp,
                            input bit poke, input int abort_at);
      int cyc, first_v;
      bit seen_done, aborted;
      int junk[4];
      junk = '{77, -77, 55, -55};
      @(negedge clk);
      set_x(xr, xi);
      out_ready = (bp == 0);
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      set_x(junk, junk);
      cyc = 0; first_v = -1; seen_done = 1'b0; aborted = 1'b0;
      while (!seen_done && !aborted && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (out_valid && first_v < 0) first_v = cyc;
         if (poke) start = (cyc == 2);
         if (bp > 0 && first_v >= 0 && cyc == first_v + bp) out_ready = 1'b1;
         if (done) seen_done = 1'b1;
         if (abort_at > 0 && cyc == abort_at) aborted = 1'b1;
      end
      start = 1'b0;
      if (aborted) begin
         rst = 1'b1;
         @(negedge clk);
         check("abort_busy", int'(busy), 0);
         check("abort_valid", int'(out_valid), 0);
         check("abort_done", int'(done), 0);
         check("abort_idx", int'(out_idx), 0);
         check("abort_out_r", int'(out_r), 0);
         check("abort_out_i", int'(out_i), 0);
         check("abort_rows_left", sb.size(), 0);
         rst = 1'b0;
         sb.delete();
         return;
      end
      check("done_seen", int'(seen_done), 1);
      check("first_valid_latency", first_v, 4);
      check("done_latency", cyc, 20 + bp);
      check("rows_drained", sb.size(), 0);
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
      check("idle_after_done", int'(busy), 0);
      if (poke) begin
         repeat (2) @(negedge clk);
         check("start_not_queued", int'(busy) | int'(out_valid), 0);
      end
   endtask

   initial begin
      int xr[4], xi[4], er[4], ei[4];
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      xr = '{0, 0, 0, 0};
      set_x(xr, xr);
      repeat (3) @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_valid", int'(out_valid), 0);
      check("reset_done", int'(done), 0);
      check("reset_idx", int'(out_idx), 0);
      check("reset_out_r", int'(out_r), 0);
      check("reset_out_i", int'(out_i), 0);
      rst = 1'b0;

      // Impulse
      xr = '{100, 0, 0, 0}; xi = '{0, 0, 0, 0};
      er = '{100, 100, 100, 100}; ei = '{0, 0, 0, 0};
      push_rows(er, ei, 4);
      run_xform(xr, xi, 0, 1'b0, 0);

      // Constant
      xr = '{10, 10, 10, 10}; xi = '{0, 0, 0, 0};
      er = '{40, 0, 0, 0}; ei = '{0, 0, 0, 0};
      push_rows(er, ei, 4);
      run_xform(xr, xi, 0, 1'b0, 0);

      // Phase ramp, with a stray start during MAC
      xr = '{0, 16, 0, 0}; xi = '{0, 0, 0, 0};
      er = '{16, 0, -16, 0}; ei = '{0, 16, 0, -16};
      push_rows(er, ei, 4);
      run_xform(xr, xi, 0, 1'b1, 0);

      // Extremes with backpressure on row 0
      xr = '{-128, -128, -128, -128}; xi = '{-128, -128, -128, -128};
      er = '{-512, 0, 0, 0}; ei = '{-512, 0, 0, 0};
      push_rows(er, ei, 4);
      run_xform(xr, xi, 3, 1'b0, 0);

      // Reset during row 2 MAC: only rows 0 and 1 ever appear
      xr = '{10, 10, 10, 10}; xi = '{0, 0, 0, 0};
      er = '{40, 0, 0, 0}; ei = '{0, 0, 0, 0};
      push_rows(er, ei, 2);
      run_xform(xr, xi, 0, 1'b0, 12);

      // Fresh start after reset
      xr = '{0, 16, 0, 0}; xi = '{0, 0, 0, 0};
      er = '{16, 0, -16, 0}; ei = '{0, 16, 0, -16};
      push_rows(er, ei, 4);
      run_xform(xr, xi, 0, 1'b0, 0);

      // Odd value: exposes truncation toward -inf when normalising
      xr = '{0, -3, 0, 0}; xi = '{0, 0, 0, 0};
      er = '{-3, 0, 3, 0}; ei = '{0, -3, 0, 3};
      push_rows(er, ei, 4);
      run_xform(xr, xi, 0, 1'b0, 0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
